// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller.
// Provides the datapath widths, the buffered LSU write-back entry type and a
// small helper that turns a register index into a one-hot scoreboard mask.
package rf_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One buffered load result waiting for the register-file write port.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // One-hot mask of a register index, used to set/clear scoreboard bits.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] mask;
    mask = {NUM_REGS{1'b0}};
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order synchronous FIFO of load write-back entries.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : enqueue request and entry (ignored while full)
//   pop          : dequeue request (ignored while empty)
//   head         : entry at the head of the queue (valid when !empty)
//   full, empty  : occupancy flags derived from the registered count
module rf_wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == {(AW+1){1'b0}});
  // A full FIFO refuses a push even when it pops in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array: written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy count; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port sequencer and load hazard scoreboard.
// The ALU result has fixed priority on the single write port; load results are
// buffered in an in-order FIFO and drained whenever the ALU is idle. A busy bit
// per register blocks issue of instructions that read or overwrite a register
// with an outstanding load.
// Ports:
//   issue_*        : instruction presented by the issue stage; issue_stall
//                    (combinational) tells it to hold
//   alu_*          : single-cycle ALU result, no backpressure
//   lsu_*          : load result handshake, lsu_ready = FIFO not full
//   RegWrite/rd/WriteData : registered RegFile write port
//   loads_pending  : loads issued but not yet written back
module rf_writeback_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int LSU_BUF_DEPTH = 2,
  parameter int MAX_OUT_LOADS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_is_load,
  output logic                  issue_stall,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       WriteData,
  output logic [3:0]            loads_pending
);

  localparam logic [3:0] MAX_LOADS = 4'(MAX_OUT_LOADS);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [3:0]          pending_next;
  logic                load_accept;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  wb_entry_t           fifo_din;
  wb_entry_t           fifo_head;

  assign fifo_din  = '{rd: lsu_rd, data: lsu_data};
  assign lsu_ready = ~fifo_full;
  assign fifo_push = lsu_valid & ~fifo_full;
  // The FIFO only gets the write port in cycles the ALU leaves free.
  assign fifo_pop  = ~alu_valid & ~fifo_empty;

  rf_wb_fifo #(
    .DEPTH (LSU_BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Hazard check: RAW/WAW against busy registers, plus the load-slot limit.
  always_comb begin
    issue_stall = 1'b0;
    if (issue_valid) begin
      issue_stall = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd] |
                    (issue_is_load & (loads_pending == MAX_LOADS));
    end else begin
      issue_stall = 1'b0;
    end
  end

  assign load_accept = issue_valid & issue_is_load & ~issue_stall;

  // Next scoreboard: clear on pop first so a same-cycle set for that rd wins.
  always_comb begin
    busy_next = busy;
    if (fifo_pop) begin
      busy_next = busy_next & ~reg_onehot(fifo_head.rd);
    end else begin
      busy_next = busy_next;
    end
    if (load_accept) begin
      busy_next = busy_next | reg_onehot(issue_rd);
    end else begin
      busy_next = busy_next;
    end
    busy_next[0] = 1'b0;
  end

  // Next outstanding-load count; loads to x0 still occupy a slot.
  always_comb begin
    pending_next = loads_pending;
    case ({load_accept, fifo_pop})
      2'b10:   pending_next = loads_pending + 4'd1;
      2'b01:   pending_next = loads_pending - 4'd1;
      default: pending_next = loads_pending;
    endcase
  end

  // Scoreboard and load counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= {NUM_REGS{1'b0}};
      loads_pending <= 4'd0;
    end else begin
      busy          <= busy_next;
      loads_pending <= pending_next;
    end
  end

  // Write-port registers: ALU first, then FIFO head; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      rd        <= {REG_ADDR_W{1'b0}};
      WriteData <= {XLEN{1'b0}};
    end else if (alu_valid) begin
      RegWrite  <= (alu_rd != {REG_ADDR_W{1'b0}});
      rd        <= alu_rd;
      WriteData <= alu_data;
    end else if (fifo_pop) begin
      RegWrite  <= (fifo_head.rd != {REG_ADDR_W{1'b0}});
      rd        <= fifo_head.rd;
      WriteData <= fifo_head.data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: directed table, hand-written
// corner sequences and a randomized phase against a queue-based model.
module tb_rf_writeback_ctrl;
  import rf_ctrl_pkg::*;

  localparam int DEPTH = 2;
  localparam int MAXL  = 4;

  logic        clk;
  logic        rst_n;
  logic        issue_valid, issue_is_load, issue_stall;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WriteData;
  logic [3:0]  loads_pending;

  rf_writeback_ctrl #(.LSU_BUF_DEPTH(DEPTH), .MAX_OUT_LOADS(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_is_load(issue_is_load), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData), .loads_pending(loads_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy [32];
  int          m_pend;
  wb_entry_t   m_fifo [$];
  logic [4:0]  m_wait [$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        dut_stall;
  logic        dut_ready;

  typedef struct {
    logic iv; logic il; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rdi;
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic e_stall; logic e_we; logic [4:0] e_rd; logic [31:0] e_wd; logic [3:0] e_pend;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_pend = 0;
    m_fifo.delete();
    m_wait.delete();
    m_we = 1'b0; m_rd = 5'd0; m_wd = 32'd0;
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; issue_is_load = 1'b0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    #1;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_pending", 32'(loads_pending), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update model, check port.
  task automatic step(input logic iv, input logic il, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rdi, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic s, rdy, acc, psh, pp;
    @(negedge clk);
    issue_valid = iv; issue_is_load = il; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rdi;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    s   = iv && (m_busy[rs1] || m_busy[rs2] || m_busy[rdi] || (il && m_pend == MAXL));
    rdy = (m_fifo.size() < DEPTH);
    dut_stall = issue_stall;
    dut_ready = lsu_ready;
    chk("issue_stall", 32'(issue_stall), 32'(s));
    chk("lsu_ready", 32'(lsu_ready), 32'(rdy));
    if (av && m_busy[ard]) begin
      errors++;
      $display("FAIL alu_busy: alu_rd %0d is busy", ard);
    end
    acc = iv && il && !s;
    psh = lv && rdy;
    pp  = !av && (m_fifo.size() > 0);
    @(posedge clk);
    #1;
    if (av) begin
      m_we = (ard != 5'd0); m_rd = ard; m_wd = ad;
    end else if (pp) begin
      m_we = (m_fifo[0].rd != 5'd0); m_rd = m_fifo[0].rd; m_wd = m_fifo[0].data;
    end else begin
      m_we = 1'b0;
    end
    if (pp) begin
      m_busy[m_fifo[0].rd] = 1'b0;
      void'(m_fifo.pop_front());
      m_pend--;
    end
    if (acc) begin
      if (rdi != 5'd0) m_busy[rdi] = 1'b1;
      m_pend++;
      m_wait.push_back(rdi);
    end
    if (psh) begin
      m_fifo.push_back('{rd: lrd, data: ld});
      if (m_wait.size() > 0) void'(m_wait.pop_front());
    end
    chk("RegWrite", 32'(RegWrite), 32'(m_we));
    chk("rd", 32'(rd), 32'(m_rd));
    chk("WriteData", WriteData, m_wd);
    chk("loads_pending", 32'(loads_pending), 32'(m_pend));
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic load_step(input logic [4:0] r);
    step(1'b1, 1'b1, 5'd0, 5'd0, r, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic iv, il, av, lv;
    logic [4:0] rs1, rs2, rdi, ard, lrd;
    logic [31:0] ad, ld;

    //        iv il rs1 rs2 rdi  av ard ad            lv lrd ld         st we rd  wd            pend
    vt[0]  = '{0, 0, 0, 0, 0,    0, 0, 32'h0,         0, 0, 32'h0,      0, 0, 0,  32'h0,        0};
    vt[1]  = '{0, 0, 0, 0, 0,    1, 5, 32'hDEADBEEF,  0, 0, 32'h0,      0, 1, 5,  32'hDEADBEEF, 0};
    vt[2]  = '{0, 0, 0, 0, 0,    0, 0, 32'h0,         0, 0, 32'h0,      0, 0, 5,  32'hDEADBEEF, 0};
    vt[3]  = '{1, 1, 1, 2, 3,    0, 0, 32'h0,         0, 0, 32'h0,      0, 0, 5,  32'hDEADBEEF, 1};
    vt[4]  = '{1, 0, 3, 0, 9,    1, 4, 32'hB,         1, 3, 32'hA,      1, 1, 4,  32'hB,        1};
    vt[5]  = '{1, 0, 3, 0, 9,    0, 0, 32'h0,         0, 0, 32'h0,      1, 1, 3,  32'hA,        0};
    vt[6]  = '{1, 0, 3, 0, 9,    0, 0, 32'h0,         0, 0, 32'h0,      0, 0, 3,  32'hA,        0};
    vt[7]  = '{1, 1, 0, 0, 0,    0, 0, 32'h0,         0, 0, 32'h0,      0, 0, 3,  32'hA,        1};
    vt[8]  = '{0, 0, 0, 0, 0,    0, 0, 32'h0,         1, 0, 32'h55,     0, 0, 3,  32'hA,        1};
    vt[9]  = '{0, 0, 0, 0, 0,    0, 0, 32'h0,         0, 0, 32'h0,      0, 0, 0,  32'h55,       0};
    vt[10] = '{0, 0, 0, 0, 0,    1, 0, 32'h77,        0, 0, 32'h0,      0, 0, 0,  32'h77,       0};
    vt[11] = '{1, 1, 0, 0, 7,    0, 0, 32'h0,         0, 0, 32'h0,      0, 0, 0,  32'h77,       1};
    vt[12] = '{1, 0, 7, 0, 8,    0, 0, 32'h0,         1, 7, 32'h1234,   1, 0, 0,  32'h77,       1};
    vt[13] = '{1, 0, 7, 0, 8,    0, 0, 32'h0,         0, 0, 32'h0,      1, 1, 7,  32'h1234,     0};
    vt[14] = '{1, 0, 7, 0, 8,    0, 0, 32'h0,         0, 0, 32'h0,      0, 0, 7,  32'h1234,     0};

    rst_n = 1'b0;
    drive_idle();
    model_clear();
    do_reset();

    // Directed table
    for (int i = 0; i < 15; i++) begin
      step(vt[i].iv, vt[i].il, vt[i].rs1, vt[i].rs2, vt[i].rdi, vt[i].av, vt[i].ard, vt[i].ad,
           vt[i].lv, vt[i].lrd, vt[i].ld);
      chk($sformatf("tbl%0d_stall", i), 32'(dut_stall), 32'(vt[i].e_stall));
      chk($sformatf("tbl%0d_we", i), 32'(RegWrite), 32'(vt[i].e_we));
      chk($sformatf("tbl%0d_rd", i), 32'(rd), 32'(vt[i].e_rd));
      chk($sformatf("tbl%0d_wd", i), WriteData, vt[i].e_wd);
      chk($sformatf("tbl%0d_pend", i), 32'(loads_pending), 32'(vt[i].e_pend));
    end

    // FIFO fill under sustained ALU traffic, no pop-through, in-order drain
    do_reset();
    load_step(5'd10); load_step(5'd11); load_step(5'd12);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h100, 1'b1, 5'd10, 32'hAA);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd21, 32'h101, 1'b1, 5'd11, 32'hBB);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd22, 32'h102, 1'b1, 5'd12, 32'hCC);
    chk("full_ready", 32'(dut_ready), 32'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hCC);
    chk("poppass_ready", 32'(dut_ready), 32'd0);
    chk("drain1_rd", 32'(rd), 32'd10);
    chk("drain1_wd", WriteData, 32'hAA);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hCC);
    chk("refill_ready", 32'(dut_ready), 32'd1);
    chk("drain2_rd", 32'(rd), 32'd11);
    chk("drain2_wd", WriteData, 32'hBB);
    idle_step();
    chk("drain3_rd", 32'(rd), 32'd12);
    chk("drain3_wd", WriteData, 32'hCC);
    idle_step();
    chk("drained_we", 32'(RegWrite), 32'd0);
    chk("drained_pend", 32'(loads_pending), 32'd0);

    // Load-slot limit and simultaneous pop + issue
    do_reset();
    load_step(5'd1); load_step(5'd2); load_step(5'd3); load_step(5'd4);
    chk("max_pend", 32'(loads_pending), 32'd4);
    load_step(5'd5);
    chk("max_stall", 32'(dut_stall), 32'd1);
    chk("max_pend_hold", 32'(loads_pending), 32'd4);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h11);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
    chk("pop1_pend", 32'(loads_pending), 32'd3);
    load_step(5'd5);
    chk("popiss_stall", 32'(dut_stall), 32'd0);
    chk("popiss_pend", 32'(loads_pending), 32'd3);

    // Asynchronous reset with FIFO occupied and busy bits set
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h33);
    @(negedge clk);
    issue_valid = 1'b1; issue_rs1 = 5'd4; issue_rs2 = 5'd5; issue_rd = 5'd6; issue_is_load = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1;
    chk("prerst_stall", 32'(issue_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(RegWrite), 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    chk("arst_wd", WriteData, 32'd0);
    chk("arst_pend", 32'(loads_pending), 32'd0);
    chk("arst_ready", 32'(lsu_ready), 32'd1);
    chk("arst_stall", 32'(issue_stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    model_clear();
    repeat (3) idle_step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      iv  = ($urandom_range(1, 0) == 1);
      il  = ($urandom_range(2, 0) == 0);
      rs1 = 5'($urandom_range(31, 0));
      rs2 = 5'($urandom_range(31, 0));
      rdi = 5'($urandom_range(31, 0));
      av  = ($urandom_range(4, 0) < 2);
      ard = 5'($urandom_range(31, 0));
      if (m_busy[ard]) av = 1'b0;
      ad  = $urandom;
      lv  = (m_wait.size() > 0) && ($urandom_range(1, 0) == 1);
      lrd = (m_wait.size() > 0) ? m_wait[0] : 5'd0;
      ld  = $urandom;
      step(iv, il, rs1, rs2, rdi, av, ard, ad, lv, lrd, ld);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
